// File: rtl/switch_sync_debounce_if.sv
// Bus bundle for the switch conditioner: raw board inputs in, conditioned levels and events out.
interface switch_sync_debounce_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;

    // Driver of the raw inputs / consumer of the conditioned outputs.
    modport master (
        output raw_in,
        input  sync_out,
        input  stable_out,
        input  rise_pulse,
        input  fall_pulse,
        input  any_change
    );

    // The conditioner itself.
    modport slave (
        input  raw_in,
        output sync_out,
        output stable_out,
        output rise_pulse,
        output fall_pulse,
        output any_change
    );
endinterface

// File: rtl/switch_sync_debounce.sv
// Multi-channel conditioner for asynchronous switch/key inputs: per-channel synchroniser,
// counter-based debounce and registered one-cycle rise/fall event pulses.
module switch_sync_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input logic                   clk,
    input logic                   reset,   // asynchronous, active-low
    switch_sync_debounce_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StStable,
        StPending
    } deb_state_e;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  stable_q;
    logic [WIDTH-1:0]                  rise_q;
    logic [WIDTH-1:0]                  fall_q;
    logic                              any_change_q;
    logic [CNT_W-1:0]                  cnt_q [WIDTH];
    deb_state_e                        chan_state [WIDTH];
    logic [WIDTH-1:0]                  accept;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Plain shift chain per channel; stage 0 is the only flop that sees the async input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
        end
    end

    // A channel is pending whenever its synchronised level disagrees with the accepted one;
    // acceptance happens on the edge that completes DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            chan_state[i] = (sync_out[i] != stable_q[i]) ? StPending : StStable;
            accept[i]     = (chan_state[i] == StPending) && (cnt_q[i] == CNT_LAST);
        end
    end

    // Debounce counters, accepted levels and the edge pulses, all updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q     <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                unique case (chan_state[i])
                    // Matching level (or a glitch that just ended): restart the full count.
                    StStable: cnt_q[i] <= '0;
                    StPending: begin
                        if (accept[i]) begin
                            stable_q[i] <= sync_out[i];
                            cnt_q[i]    <= '0;
                            rise_q[i]   <= sync_out[i];
                            fall_q[i]   <= ~sync_out[i];
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end
            any_change_q <= |accept;
        end
    end

    assign bus.sync_out   = sync_out;
    assign bus.stable_out = stable_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.any_change = any_change_q;
endmodule
